iobus_uart_tx: RTL

IOBUS_UART_TX -- requirements
Module: iobus_uart_tx

---
 rtl/iobus_uart_pkg.sv | 33 +++
 rtl/iobus_uart_tx_if.sv | 24 ++
 rtl/iobus_byte_fifo.sv | 60 ++++++
 rtl/iobus_uart_tx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/iobus_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS/CTRL bit positions, FSM state encoding and the baud divisor helper.
package iobus_uart_pkg;

    localparam logic [31:0] REG_TXDATA = 32'h0000_0000;
    localparam logic [31:0] REG_STATUS = 32'h0000_0004;
    localparam logic [31:0] REG_CTRL   = 32'h0000_0008;

    localparam int unsigned STAT_FULL    = 0;
    localparam int unsigned STAT_EMPTY   = 1;
    localparam int unsigned STAT_BUSY    = 2;
    localparam int unsigned STAT_OVF     = 3;
    localparam int unsigned STAT_COUNT   = 4;
    localparam int unsigned STAT_COUNT_W = 5;

    localparam int unsigned CTRL_TX_EN  = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_e;

    // Rounded cycles per bit; 64-bit intermediate keeps fast clocks from overflowing.
    function automatic int unsigned baud_div(input int unsigned clk_mhz, input int unsigned baud);
        longint unsigned hz;
        hz = 64'(clk_mhz) * 64'd1_000_000;
        return 32'((hz + 64'(baud / 2)) / 64'(baud));
    endfunction

endpackage

// File: rtl/iobus_uart_tx_if.sv
// MCU I/O bus as seen by a peripheral: address, write data, write strobe and
// combinational read data.
interface iobus_uart_tx_if;

    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;

    modport master (
        output IOBUS_ADDR,
        output IOBUS_OUT,
        output IOBUS_WR,
        input  IOBUS_IN
    );

    modport slave (
        input  IOBUS_ADDR,
        input  IOBUS_OUT,
        input  IOBUS_WR,
        output IOBUS_IN
    );

endinterface

// File: rtl/iobus_byte_fifo.sv
// Byte FIFO with occupancy count; pushes while full and pops while empty are ignored.
module iobus_byte_fifo #(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [7:0]    din_i,
    input  logic          pop_i,
    output logic [7:0]    dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/iobus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/CTRL register window,
// byte FIFO, bit-serialiser FSM and a registered level interrupt.
module iobus_uart_tx
    import iobus_uart_pkg::*;
#(
    parameter int unsigned CLK_RATE  = 50,
    parameter int unsigned BAUD      = 115200,
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
    parameter int unsigned DEPTH     = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    iobus_uart_tx_if.slave   bus,
    output logic             TX,
    output logic             TX_IRQ
);

    localparam int unsigned      DIV      = baud_div(CLK_RATE, BAUD);
    localparam int unsigned      CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam int unsigned      FCW      = $clog2(DEPTH) + 1;

    logic sel_txdata, sel_status, sel_ctrl;
    logic wr_txdata, wr_status, wr_ctrl;

    assign sel_txdata = (bus.IOBUS_ADDR == BASE_ADDR + REG_TXDATA);
    assign sel_status = (bus.IOBUS_ADDR == BASE_ADDR + REG_STATUS);
    assign sel_ctrl   = (bus.IOBUS_ADDR == BASE_ADDR + REG_CTRL);
    assign wr_txdata  = bus.IOBUS_WR & sel_txdata;
    assign wr_status  = bus.IOBUS_WR & sel_status;
    assign wr_ctrl    = bus.IOBUS_WR & sel_ctrl;

    logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]     fifo_dout;
    logic [FCW-1:0] fifo_count;

    assign fifo_push = wr_txdata & ~fifo_full;

    iobus_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .push_i  (fifo_push),
        .din_i   (bus.IOBUS_OUT[7:0]),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             ovf_q, ovf_d;
    logic             tx_en_q, tx_en_d;
    logic             irq_en_q, irq_en_d;
    logic             irq_q, irq_d;
    logic             busy;

    assign busy = (state_q != S_IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!fifo_empty && tx_en_q) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line level follows the current state one edge later, so TX lags the FSM by a cycle.
    always_comb begin
        tx_d = 1'b1;
        if (state_q == S_START) begin
            tx_d = 1'b0;
        end else if (state_q == S_DATA) begin
            tx_d = shift_q[0];
        end
    end

    always_comb begin
        ovf_d    = ovf_q;
        tx_en_d  = tx_en_q;
        irq_en_d = irq_en_q;
        if (wr_status && bus.IOBUS_OUT[STAT_OVF]) begin
            ovf_d = 1'b0;
        end
        // Set wins over clear so an overflow in the clearing cycle is not lost.
        if (wr_txdata && fifo_full) begin
            ovf_d = 1'b1;
        end
        if (wr_ctrl) begin
            tx_en_d  = bus.IOBUS_OUT[CTRL_TX_EN];
            irq_en_d = bus.IOBUS_OUT[CTRL_IRQ_EN];
        end
        irq_d = irq_en_q & fifo_empty & ~busy;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
            tx_en_q  <= 1'b1;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            ovf_q    <= ovf_d;
            tx_en_q  <= tx_en_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        if (sel_status) begin
            rdata[STAT_FULL]                   = fifo_full;
            rdata[STAT_EMPTY]                  = fifo_empty;
            rdata[STAT_BUSY]                   = busy;
            rdata[STAT_OVF]                    = ovf_q;
            rdata[STAT_COUNT +: STAT_COUNT_W]  = STAT_COUNT_W'(fifo_count);
        end else if (sel_ctrl) begin
            rdata[CTRL_TX_EN]  = tx_en_q;
            rdata[CTRL_IRQ_EN] = irq_en_q;
        end
    end

    assign bus.IOBUS_IN = rdata;
    assign TX           = tx_q;
    assign TX_IRQ       = irq_q;

    logic unused_bus_bits;
    assign unused_bus_bits = ^bus.IOBUS_OUT[31:8];

endmodule
